axi4_slave_mem_responder: RTL and testbench
===========================================

AXI4_SLAVE_MEM_RESPONDER -- requirements
Module: axi4_slave_mem_responder

Interface
REQ-001 The module SHALL have a single clock ACLK and a reset ARESETn that is synchronous and active-low.
REQ-002 The module SHALL take these parameters:
- ADDR_WIDTH, default 32, byte address width.
- DATA_WIDTH, default 32, data bus width; legal values 32, 64, 128.
- ID_WIDTH, default 4, transaction ID width.
- MEM_WORDS, default 1024, memory depth in DATA_WIDTH words.
- BASE_ADDR, default 0, first mapped byte address.
- RD_LATENCY, default 0, extra cycles from AR accept to first R beat; range 0-15.
REQ-003 Ports, grouped where width and direction match:
- ACLK  in  1  clock.
- ARESETn  in  1  synchronous active-low reset.
- AWVALID/ARVALID/WVALID/WLAST/BREADY/RREADY  in  1  AXI4 handshakes and last-beat flag.
- AWREADY/ARREADY/WREADY/BVALID/RVALID/RLAST  out  1  AXI4 handshakes and last-beat flag.
- AWID/ARID  in  ID_WIDTH  request IDs.
- BID/RID  out  ID_WIDTH  response IDs.
- AWADDR/ARADDR  in  ADDR_WIDTH  burst start address.
- AWLEN/ARLEN  in  8  beats minus 1.
- AWSIZE/ARSIZE  in  3  log2 of bytes per beat.
- AWBURST/ARBURST  in  2  burst type: FIXED=0, INCR=1, WRAP=2.
- WDATA  in  DATA_WIDTH  write data.
- WSTRB  in  DATA_WIDTH/8  byte-lane strobes.
- RDATA  out  DATA_WIDTH  read data.
- BRESP/RRESP  out  2  OKAY=0 or SLVERR=2.

Function
REQ-004 The write path SHALL be an FSM with states W_IDLE, W_DATA, W_RESP; AWREADY=1 only in W_IDLE.
REQ-005 The write path SHALL capture ID, address, length, size and burst on AWVALID&&AWREADY and move to W_DATA.
REQ-006 In W_DATA, WREADY SHALL be 1; each WVALID&&WREADY SHALL write only the WSTRB-enabled bytes of the addressed word, in the same ACLK edge.
REQ-007 When the beat counter reaches AWLEN, the write path SHALL go to W_RESP, with BVALID=1 and BID equal to the captured ID the next cycle.
REQ-008 BVALID, BID and BRESP SHALL hold stable until BREADY; on the handshake the write path SHALL return to W_IDLE.
REQ-009 BRESP SHALL be SLVERR if any of these occurs, else OKAY:
- any beat address outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*DATA_WIDTH/8);
- WLAST disagrees with the beat count;
- AWSIZE > log2(DATA_WIDTH/8);
- WRAP with AWLEN not in {1,3,7,15}.
REQ-010 Out-of-range beats SHALL NOT modify memory.
REQ-011 The read path SHALL be an FSM with states R_IDLE, R_WAIT, R_DATA; ARREADY=1 only in R_IDLE.
REQ-012 After AR accept, the read path SHALL stay in R_WAIT for exactly RD_LATENCY cycles (R_WAIT skipped when 0); the first RVALID SHALL assert RD_LATENCY+1 cycles after the AR handshake.
REQ-013 RVALID, RDATA, RID, RRESP and RLAST SHALL hold until RREADY; the next beat SHALL be presented the cycle after each handshake.
REQ-014 RLAST SHALL be 1 on beat ARLEN only; after the last handshake the read path SHALL return to R_IDLE.
REQ-015 RDATA SHALL be the full addressed word; for an erroring beat RDATA=0 and RRESP=SLVERR, using the REQ-009 criteria per beat.
REQ-016 Address generation, with step = 2^size:
- FIXED: the address is constant.
- INCR: address += step.
- WRAP: address += step, wrapping within an aligned window of (len+1)*step bytes.
- WRAP with an illegal length SHALL be treated as INCR and flagged SLVERR.
REQ-017 The word index SHALL be (addr-BASE_ADDR)>>log2(DATA_WIDTH/8); INCR across the 4 KB boundary is not checked.
REQ-018 Read and write paths SHALL run concurrently; a read of a word written at the same edge SHALL return the old data.

Reset
REQ-019 While ARESETn=0 at an ACLK edge, both FSMs SHALL enter their IDLE states and all outputs SHALL be 0, including AWREADY and ARREADY.
REQ-020 AWREADY and ARREADY SHALL become 1 on the first edge after ARESETn=1.
REQ-021 Reset mid-burst SHALL abandon the burst with no B or R response; memory contents SHALL NOT be reset.

Structure
REQ-022 Package axi4_responder_pkg SHALL hold the burst_e and resp_e enums, the write and read FSM state typedefs, and the WRAP-legal length constant set.
REQ-023 Sub-module axi4_burst_addr_gen SHALL compute the next address and error flag from the current address, size, length and burst; it SHALL be instantiated once per path.

Verification
REQ-024 Write INCR of 4 beats, addr 0x10, size 2, WSTRB 0xF, data 1-4, then read it back -> BRESP OKAY, RDATA 1,2,3,4, RLAST on beat 4.
REQ-025 WRAP of 4 beats at 0x38, size 2 -> beat addresses 0x38,0x3C,0x30,0x34; RRESP OKAY.
REQ-026 With RD_LATENCY=3, AR accepted at cycle t -> first RVALID at t+4; with RREADY low for 5 cycles, RDATA held stable.
REQ-027 Write to BASE_ADDR+MEM_WORDS*4 (first unmapped address) -> BRESP SLVERR and memory unchanged; read of the same address -> RDATA 0, RRESP SLVERR.
REQ-028 WSTRB 0x5 over existing word 0xAABBCCDD with WDATA 0x11223344 -> readback 0xAA22CC44.
REQ-029 Reset asserted during a W_DATA beat 2 of 4 -> no BVALID; AWREADY=1 on the first edge after release.

Source files
------------

// File: rtl/axi4_responder_pkg.sv
// Shared types and constants for the AXI4 memory responder.
package axi4_responder_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_SLVERR = 2'd2
  } resp_e;

  typedef logic [1:0] wr_state_t;
  localparam wr_state_t W_IDLE = 2'd0;
  localparam wr_state_t W_DATA = 2'd1;
  localparam wr_state_t W_RESP = 2'd2;

  typedef logic [1:0] rd_state_t;
  localparam rd_state_t R_IDLE = 2'd0;
  localparam rd_state_t R_WAIT = 2'd1;
  localparam rd_state_t R_DATA = 2'd2;

  // Burst lengths (beats minus one) allowed for WRAP bursts.
  localparam int unsigned WRAP_LEN_COUNT = 4;
  localparam logic [7:0] WRAP_LENS [WRAP_LEN_COUNT] = '{8'd1, 8'd3, 8'd7, 8'd15};

  function automatic logic wrap_len_legal(input logic [7:0] len);
    logic ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < WRAP_LEN_COUNT; i++) begin
      if (len == WRAP_LENS[i]) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Per-beat address stepping, word indexing and error flags for one AXI4 burst.
module axi4_burst_addr_gen
  import axi4_responder_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           IDX_WIDTH  = 10
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic [IDX_WIDTH-1:0]  word_idx,
  output logic                  range_err,
  output logic                  proto_err
);

  localparam int unsigned LANE_BITS = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH:0] MAP_END =
    {1'b0, BASE_ADDR} + (ADDR_WIDTH + 1)'(MEM_WORDS * (DATA_WIDTH / 8));

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] win_mask;
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  wrap_ok;

  // Next beat address, mapped word index and error classification of the current beat.
  always_comb begin
    step     = ADDR_WIDTH'(1) << size;
    win_mask = (step * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1))) - ADDR_WIDTH'(1);
    incr     = addr + step;
    wrap_ok  = wrap_len_legal(len);
    case (burst)
      BURST_FIXED: next_addr = addr;
      // An illegal WRAP length falls back to INCR stepping; proto_err reports it.
      BURST_WRAP:  next_addr = wrap_ok ? ((addr & ~win_mask) | (incr & win_mask)) : incr;
      default:     next_addr = incr;
    endcase
    proto_err = (size > 3'(LANE_BITS)) || ((burst == BURST_WRAP) && !wrap_ok);
    range_err = ({1'b0, addr} < {1'b0, BASE_ADDR}) || ({1'b0, addr} >= MAP_END);
    offset    = addr - BASE_ADDR;
    word_idx  = IDX_WIDTH'(offset >> LANE_BITS);
  end

endmodule

// File: rtl/axi4_slave_mem_responder.sv
// AXI4 slave backed by a word-organised memory; independent write and read FSMs.
module axi4_slave_mem_responder
  import axi4_responder_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ID_WIDTH   = 4,
  parameter int unsigned           MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           RD_LATENCY = 0
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    WVALID,
  output logic                    WREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  output logic                    BVALID,
  input  logic                    BREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic up;

  wr_state_t             w_state;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len;
  logic [7:0]            w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_err;
  resp_e                 b_resp;
  logic [ADDR_WIDTH-1:0] w_next;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_range_err;
  logic                  w_proto_err;
  logic                  w_beat_bad;

  rd_state_t             r_state;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [3:0]            r_wait;
  logic [DATA_WIDTH-1:0] rdata_q;
  resp_e                 r_resp;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [2:0]            g_size;
  logic [7:0]            g_len;
  logic [1:0]            g_burst;
  logic [ADDR_WIDTH-1:0] r_next;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_range_err;
  logic                  r_proto_err;
  logic                  r_bad;

  // Ready flags stay low until the first edge with reset released.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) up <= 1'b0;
    else          up <= 1'b1;
  end

  assign AWREADY = up && (w_state == W_IDLE);
  assign WREADY  = (w_state == W_DATA);
  assign BVALID  = (w_state == W_RESP);
  assign BID     = w_id;
  assign BRESP   = b_resp;

  axi4_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS),
    .BASE_ADDR  (BASE_ADDR),
    .IDX_WIDTH  (IDX_W)
  ) u_wr_gen (
    .addr      (w_addr),
    .size      (w_size),
    .len       (w_len),
    .burst     (w_burst),
    .next_addr (w_next),
    .word_idx  (w_idx),
    .range_err (w_range_err),
    .proto_err (w_proto_err)
  );

  assign w_beat_bad = w_range_err || w_proto_err || (WLAST != (w_cnt == w_len));

  // Write FSM: accept AW, count W beats while accumulating errors, hold B until taken.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
      b_resp  <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (AWVALID && up) begin
            w_id    <= AWID;
            w_addr  <= AWADDR;
            w_len   <= AWLEN;
            w_size  <= AWSIZE;
            w_burst <= AWBURST;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (WVALID) begin
            if (w_cnt == w_len) begin
              b_resp  <= (w_err || w_beat_bad) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end else begin
              w_cnt  <= w_cnt + 8'd1;
              w_addr <= w_next;
              w_err  <= w_err || w_beat_bad;
            end
          end
        end
        W_RESP: begin
          if (BREADY) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Byte-lane write of each accepted in-range W beat; memory is never cleared.
  always_ff @(posedge ACLK) begin
    if (ARESETn && (w_state == W_DATA) && WVALID && !w_range_err) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) mem[w_idx][b*8 +: 8] <= WDATA[b*8 +: 8];
      end
    end
  end

  // Read address generator sees the AR channel while idle, the burst pointer otherwise.
  always_comb begin
    if (r_state == R_IDLE) begin
      g_addr  = ARADDR;
      g_size  = ARSIZE;
      g_len   = ARLEN;
      g_burst = ARBURST;
    end else begin
      g_addr  = r_addr;
      g_size  = r_size;
      g_len   = r_len;
      g_burst = r_burst;
    end
  end

  axi4_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS),
    .BASE_ADDR  (BASE_ADDR),
    .IDX_WIDTH  (IDX_W)
  ) u_rd_gen (
    .addr      (g_addr),
    .size      (g_size),
    .len       (g_len),
    .burst     (g_burst),
    .next_addr (r_next),
    .word_idx  (r_idx),
    .range_err (r_range_err),
    .proto_err (r_proto_err)
  );

  assign r_bad   = r_range_err || r_proto_err;
  assign ARREADY = up && (r_state == R_IDLE);
  assign RVALID  = (r_state == R_DATA);
  assign RLAST   = RVALID && (r_cnt == r_len);
  assign RID     = r_id;
  assign RDATA   = rdata_q;
  assign RRESP   = r_resp;

  // Read FSM. r_addr always points at the beat to fetch next, so each load of
  // rdata_q reads memory through the generator and advances the pointer together.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_wait  <= '0;
      rdata_q <= '0;
      r_resp  <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ARVALID && up) begin
            r_id    <= ARID;
            r_len   <= ARLEN;
            r_size  <= ARSIZE;
            r_burst <= ARBURST;
            r_cnt   <= '0;
            if (RD_LATENCY == 0) begin
              rdata_q <= r_bad ? '0 : mem[r_idx];
              r_resp  <= r_bad ? RESP_SLVERR : RESP_OKAY;
              r_addr  <= r_next;
              r_state <= R_DATA;
            end else begin
              r_addr  <= ARADDR;
              r_wait  <= 4'(RD_LATENCY - 1);
              r_state <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (r_wait == 4'd0) begin
            rdata_q <= r_bad ? '0 : mem[r_idx];
            r_resp  <= r_bad ? RESP_SLVERR : RESP_OKAY;
            r_addr  <= r_next;
            r_state <= R_DATA;
          end else begin
            r_wait <= r_wait - 4'd1;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            if (r_cnt == r_len) begin
              r_state <= R_IDLE;
            end else begin
              r_cnt   <= r_cnt + 8'd1;
              rdata_q <= r_bad ? '0 : mem[r_idx];
              r_resp  <= r_bad ? RESP_SLVERR : RESP_OKAY;
              r_addr  <= r_next;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_slave_mem_responder.sv
// Self-checking bench for axi4_slave_mem_responder with a word-array reference model.
module tb_axi4_slave_mem_responder;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned IW    = 4;
  localparam int unsigned WORDS = 64;
  localparam int unsigned LAT   = 3;
  localparam int unsigned LIMIT = WORDS * 4;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic          AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic [IW-1:0] AWID, ARID, BID, RID;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [7:0]    AWLEN, ARLEN;
  logic [2:0]    AWSIZE, ARSIZE;
  logic [1:0]    AWBURST, ARBURST, BRESP, RRESP;
  logic [DW-1:0] WDATA, RDATA;
  logic [3:0]    WSTRB;

  always #5 ACLK = ~ACLK;

  axi4_slave_mem_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IW),
    .MEM_WORDS  (WORDS),
    .BASE_ADDR  (32'h0),
    .RD_LATENCY (LAT)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWADDR(AWADDR),
    .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARADDR(ARADDR),
    .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .RVALID(RVALID), .RREADY(RREADY), .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] model [WORDS];
  logic [31:0] wbuf  [256];
  logic [3:0]  sbuf  [256];
  logic [7:0]  wrap_lens [4] = '{8'd1, 8'd3, 8'd7, 8'd15};

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic wrap_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Address of beat i computed directly from the burst start.
  function automatic logic [31:0] ref_addr(input logic [31:0] start, input logic [2:0] size,
                                           input logic [7:0] len, input logic [1:0] burst,
                                           input int unsigned i);
    longint unsigned step, win, lo;
    step = longint'(1) << size;
    if (burst == 2'd0) return start;
    if (burst == 2'd2 && wrap_ok(len)) begin
      win = step * (longint'(len) + 1);
      lo  = (longint'(start) / win) * win;
      return 32'(lo + ((longint'(start) - lo + i * step) % win));
    end
    return 32'(longint'(start) + i * step);
  endfunction

  task automatic fill_random(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      wbuf[i] = $urandom;
      sbuf[i] = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int bad_beat);
    logic        err;
    logic [31:0] a;
    int          n;
    err = (size > 3'd2) || (burst == 2'd2 && !wrap_ok(len));
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    n = 0;
    while (AWREADY !== 1'b1 && n < 50) begin tick(); n++; end
    chk("awready", AWREADY, 1);
    tick();
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      WVALID = 1'b1; WDATA = wbuf[i]; WSTRB = sbuf[i];
      WLAST = (i == int'(len)) ^ (i == bad_beat);
      if (i == bad_beat) err = 1'b1;
      n = 0;
      while (WREADY !== 1'b1 && n < 50) begin tick(); n++; end
      chk("wready", WREADY, 1);
      a = ref_addr(addr, size, len, burst, i);
      if (a < LIMIT) begin
        for (int b = 0; b < 4; b++)
          if (sbuf[i][b]) model[a[7:2]][b*8 +: 8] = wbuf[i][b*8 +: 8];
      end else begin
        err = 1'b1;
      end
      tick();
    end
    WVALID = 1'b0; WLAST = 1'b0;
    chk("bvalid_next", BVALID, 1);
    chk("bid", BID, id);
    chk("bresp", BRESP, err ? 2 : 0);
    tick();
    chk("bvalid_hold", BVALID, 1);
    chk("bresp_hold", BRESP, err ? 2 : 0);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    chk("bvalid_clear", BVALID, 0);
    chk("awready_back", AWREADY, 1);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input int stall_beat, input int stall_cycles);
    logic [31:0] a, exp;
    logic        bad;
    int          n;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    n = 0;
    while (ARREADY !== 1'b1 && n < 50) begin tick(); n++; end
    chk("arready", ARREADY, 1);
    tick();
    ARVALID = 1'b0;
    for (int k = 0; k < int'(LAT); k++) begin
      chk("rvalid_early", RVALID, 0);
      tick();
    end
    chk("rvalid_first", RVALID, 1);
    for (int i = 0; i <= int'(len); i++) begin
      a   = ref_addr(addr, size, len, burst, i);
      bad = (size > 3'd2) || (burst == 2'd2 && !wrap_ok(len)) || (a >= LIMIT);
      exp = bad ? 32'h0 : model[a[7:2]];
      n = 0;
      while (RVALID !== 1'b1 && n < 50) begin tick(); n++; end
      if (i == stall_beat) begin
        for (int s = 0; s < stall_cycles; s++) begin
          tick();
          chk("rvalid_hold", RVALID, 1);
          chk("rdata_hold", RDATA, exp);
        end
      end
      chk("rdata", RDATA, exp);
      chk("rresp", RRESP, bad ? 2 : 0);
      chk("rlast", RLAST, (i == int'(len)) ? 1 : 0);
      chk("rid", RID, id);
      RREADY = 1'b1;
      tick();
      RREADY = 1'b0;
      if (i < int'(len)) chk("rvalid_next", RVALID, 1);
    end
    chk("rvalid_done", RVALID, 0);
    chk("arready_back", ARREADY, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired: errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [7:0]  len;
    logic [31:0] addr;

    ARESETn = 1'b0;
    AWVALID = 0; AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0;
    WVALID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; BREADY = 0;
    ARVALID = 0; ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; RREADY = 0;
    repeat (3) tick();

    chk("rst_awready", AWREADY, 0);
    chk("rst_arready", ARREADY, 0);
    chk("rst_wready", WREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_rlast", RLAST, 0);
    chk("rst_bid", BID, 0);
    chk("rst_rid", RID, 0);
    chk("rst_bresp", BRESP, 0);
    chk("rst_rresp", RRESP, 0);
    chk("rst_rdata", RDATA, 0);
    ARESETn = 1'b1;
    chk("awready_pre_edge", AWREADY, 0);
    tick();
    chk("awready_after_release", AWREADY, 1);
    chk("arready_after_release", ARREADY, 1);

    // Preload every word so later reads are fully defined.
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 16; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
      do_write(4'(p), 32'(p * 64), 8'd15, 3'd2, 2'd1, -1);
    end

    // INCR 4 beats at 0x10 with data 1..4; hold beat 0 for 5 cycles on readback.
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
    do_write(4'h3, 32'h10, 8'd3, 3'd2, 2'd1, -1);
    do_read(4'h5, 32'h10, 8'd3, 3'd2, 2'd1, 0, 5);

    // WRAP 4 beats from 0x38: 0x38, 0x3C, 0x30, 0x34.
    do_read(4'h6, 32'h38, 8'd3, 3'd2, 2'd2, -1, 0);

    // First unmapped address: write rejected, read errors, word 0 untouched.
    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
    do_write(4'h7, LIMIT, 8'd0, 3'd2, 2'd1, -1);
    do_read(4'h8, LIMIT, 8'd0, 3'd2, 2'd1, -1, 0);
    do_read(4'h9, 32'h0, 8'd0, 3'd2, 2'd1, -1, 0);

    // Strobe merge: 0xAABBCCDD then 0x11223344 with lanes 0 and 2.
    wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'hF;
    do_write(4'h1, 32'h80, 8'd0, 3'd2, 2'd1, -1);
    wbuf[0] = 32'h11223344; sbuf[0] = 4'h5;
    do_write(4'h2, 32'h80, 8'd0, 3'd2, 2'd1, -1);
    do_read(4'h3, 32'h80, 8'd0, 3'd2, 2'd1, -1, 0);

    // Protocol errors: early WLAST, illegal WRAP length, oversize beat.
    fill_random(2);
    do_write(4'hA, 32'h40, 8'd1, 3'd2, 2'd1, 0);
    do_read(4'hB, 32'h20, 8'd2, 3'd2, 2'd2, -1, 0);
    do_read(4'hC, 32'h20, 8'd0, 3'd3, 2'd1, -1, 0);
    do_read(4'hD, 32'hF8, 8'd3, 3'd2, 2'd1, 1, 2);

    // Randomised bursts, each read back with the same shape.
    for (int t = 0; t < 10; t++) begin
      size  = 3'($urandom_range(0, 2));
      burst = 2'($urandom_range(0, 2));
      len   = (burst == 2'd2) ? wrap_lens[$urandom_range(0, 3)] : 8'($urandom_range(0, 7));
      addr  = 32'($urandom_range(0, 'h11F)) & ~((32'd1 << size) - 32'd1);
      fill_random(16);
      do_write(4'(t), addr, len, size, burst, -1);
      do_read(4'(~t), addr, len, size, burst, int'($urandom_range(0, len)), int'($urandom_range(0, 2)));
    end

    // Reset on beat 2 of a 4-beat write; beat 2 carries the word's current value.
    wbuf[0] = $urandom;
    AWID = 4'h4; AWADDR = 32'h60; AWLEN = 8'd3; AWSIZE = 3'd2; AWBURST = 2'd1; AWVALID = 1'b1;
    n = 0;
    while (AWREADY !== 1'b1 && n < 50) begin tick(); n++; end
    chk("mid_awready", AWREADY, 1);
    tick();
    AWVALID = 1'b0;
    WVALID = 1'b1; WDATA = wbuf[0]; WSTRB = 4'hF; WLAST = 1'b0;
    tick();
    model[24] = wbuf[0];
    WDATA = model[25];
    ARESETn = 1'b0;
    tick();
    WVALID = 1'b0;
    chk("mid_rst_bvalid", BVALID, 0);
    chk("mid_rst_awready", AWREADY, 0);
    chk("mid_rst_wready", WREADY, 0);
    tick();
    ARESETn = 1'b1;
    chk("mid_pre_edge_awready", AWREADY, 0);
    tick();
    chk("mid_post_awready", AWREADY, 1);
    chk("mid_post_bvalid", BVALID, 0);
    chk("mid_post_wready", WREADY, 0);
    repeat (3) begin
      tick();
      chk("mid_no_bvalid", BVALID, 0);
    end
    do_read(4'hE, 32'h60, 8'd1, 3'd2, 2'd1, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
